// File: rtl/nx_stream_arbiter_if.sv
// Nexus stream arbiter bundle: REQUESTERS inbound message streams, one merged
// outbound stream and the current grant vector. Names are seen from the arbiter.
interface nx_stream_arbiter_if #(
    parameter int REQUESTERS = 4,
    parameter int DATA_W     = 32
);
    typedef logic [DATA_W-1:0] nx_message_t;

    nx_message_t [REQUESTERS-1:0] ib_nx_data_i;
    logic        [REQUESTERS-1:0] ib_nx_valid_i;
    logic        [REQUESTERS-1:0] ib_nx_ready_o;
    nx_message_t                  ob_nx_data_o;
    logic                         ob_nx_valid_o;
    logic                         ob_nx_ready_i;
    logic        [REQUESTERS-1:0] grant_o;

    // Arbiter side.
    modport slave (
        input  ib_nx_data_i, ib_nx_valid_i, ob_nx_ready_i,
        output ib_nx_ready_o, ob_nx_data_o, ob_nx_valid_o, grant_o
    );

    // Sources and downstream bridge side.
    modport master (
        output ib_nx_data_i, ib_nx_valid_i, ob_nx_ready_i,
        input  ib_nx_ready_o, ob_nx_data_o, ob_nx_valid_o, grant_o
    );
endinterface

// File: rtl/nx_stream_arbiter.sv
// Round-robin burst arbiter merging several Nexus message streams into one
// registered output stage. A grant is held for up to MAX_BURST messages or
// until the granted source drains; the hand-over to the next source costs no
// cycle, only arbitration out of IDLE does.
module nx_stream_arbiter #(
    parameter int REQUESTERS = 4,
    parameter int MAX_BURST  = 4,
    parameter int DATA_W     = 32
) (
    input logic                clk_i,
    input logic                rst_ni,
    nx_stream_arbiter_if.slave nx
);
    localparam int PTR_W = $clog2(REQUESTERS);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef logic [DATA_W-1:0] nx_message_t;
    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t                r_state,     w_state_nxt;
    logic [REQUESTERS-1:0] r_grant,     w_grant_nxt;
    logic [PTR_W-1:0]      r_rr_ptr,    w_rr_ptr_nxt;
    logic [CNT_W-1:0]      r_burst_cnt, w_burst_cnt_nxt;
    nx_message_t           r_ob_data;
    logic                  r_ob_valid;

    logic                  w_locked;
    logic                  w_slot_free;
    logic                  w_g_valid;
    logic                  w_xfer;
    logic                  w_last_beat;
    logic                  w_release;
    logic                  w_found;
    logic [PTR_W-1:0]      w_g_idx;
    logic [PTR_W-1:0]      w_g_next;
    logic [PTR_W-1:0]      w_search_start;
    logic [PTR_W-1:0]      w_scan;
    logic [PTR_W-1:0]      w_win_idx;
    logic [REQUESTERS-1:0] w_search_req;
    logic [REQUESTERS-1:0] w_win_onehot;
    nx_message_t           w_g_data;

    assign w_locked    = (r_state == ST_LOCKED);
    assign w_slot_free = !r_ob_valid || nx.ob_nx_ready_i;
    assign w_g_valid   = |(r_grant & nx.ib_nx_valid_i);
    assign w_xfer      = w_locked && w_g_valid && w_slot_free;
    assign w_last_beat = (r_burst_cnt == CNT_W'(MAX_BURST - 1));
    // A drained source releases even while the output is stalled.
    assign w_release   = w_locked && ((w_xfer && w_last_beat) || !w_g_valid);

    assign w_g_next       = (w_g_idx == PTR_W'(REQUESTERS - 1)) ? '0 : w_g_idx + 1'b1;
    assign w_g_data       = nx.ib_nx_data_i[w_g_idx];
    // In IDLE r_grant is zero, so the mask only removes the outgoing owner.
    assign w_search_start = w_locked ? w_g_next : r_rr_ptr;
    assign w_search_req   = nx.ib_nx_valid_i & ~r_grant;

    // Encode the one-hot grant into an index for the data mux and pointer.
    // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        w_g_idx = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (r_grant[i]) w_g_idx = PTR_W'(i);
        end
    end

    // Rotating priority search: first valid at or above the start index wins.
    always_comb begin
        w_found      = 1'b0;
        w_win_idx    = '0;
        w_scan       = '0;
        w_win_onehot = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            w_scan = PTR_W'((int'(w_search_start) + i) % REQUESTERS);
            if (!w_found && w_search_req[w_scan]) begin
                w_found   = 1'b1;
                w_win_idx = w_scan;
            end
        end
        w_win_onehot[w_win_idx] = 1'b1;
    end

    // Next-state logic for arbitration state, grant, pointer and burst count.
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_burst_cnt_nxt = r_burst_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt     = ST_LOCKED;
                    w_grant_nxt     = w_win_onehot;
                    w_burst_cnt_nxt = '0;
                end
            end
            ST_LOCKED: begin
                if (w_release) begin
                    w_rr_ptr_nxt    = w_g_next;
                    w_burst_cnt_nxt = '0;
                    if (w_found) begin
                        w_grant_nxt = w_win_onehot;
                    end else begin
                        w_grant_nxt = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_xfer) begin
                    w_burst_cnt_nxt = r_burst_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // Arbitration state registers.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    // Output stage: load on transfer, empty when consumed with nothing new behind it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ob_data  <= '0;
            r_ob_valid <= 1'b0;
        end else if (w_xfer) begin
            r_ob_data  <= w_g_data;
            r_ob_valid <= 1'b1;
        end else if (nx.ob_nx_ready_i && r_ob_valid) begin
            r_ob_valid <= 1'b0;
        end
    end

    assign nx.ib_nx_ready_o = (w_locked && w_slot_free) ? r_grant : '0;
    assign nx.ob_nx_data_o  = r_ob_data;
    assign nx.ob_nx_valid_o = r_ob_valid;
    assign nx.grant_o       = r_grant;
endmodule

// File: tb/tb_nx_stream_arbiter.sv
// Bench for nx_stream_arbiter: a per-cycle vector table for the single-source
// burst case, then sequences with a source model and per-requester scoreboard.
// dut_a uses MAX_BURST=4, dut_b MAX_BURST=1; both see the same stimulus.
module tb_nx_stream_arbiter;
    logic clk;
    logic rst_n;
    logic use_b;
    logic ob_rdy;

    int n_checks = 0;
    int n_fail   = 0;

    nx_stream_arbiter_if #(.REQUESTERS(4), .DATA_W(32)) bus_a ();
    nx_stream_arbiter_if #(.REQUESTERS(4), .DATA_W(32)) bus_b ();

    nx_stream_arbiter #(.REQUESTERS(4), .MAX_BURST(4), .DATA_W(32)) dut_a (
        .clk_i (clk),
        .rst_ni(rst_n),
        .nx    (bus_a.slave)
    );

    nx_stream_arbiter #(.REQUESTERS(4), .MAX_BURST(1), .DATA_W(32)) dut_b (
        .clk_i (clk),
        .rst_ni(rst_n),
        .nx    (bus_b.slave)
    );

    logic [3:0]  m_grant, m_ready;
    logic        m_ovalid;
    logic [31:0] m_odata;
    assign m_grant  = use_b ? bus_b.grant_o       : bus_a.grant_o;
    assign m_ready  = use_b ? bus_b.ib_nx_ready_o : bus_a.ib_nx_ready_o;
    assign m_ovalid = use_b ? bus_b.ob_nx_valid_o : bus_a.ob_nx_valid_o;
    assign m_odata  = use_b ? bus_b.ob_nx_data_o  : bus_a.ob_nx_data_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic [3:0] v, input logic [3:0][31:0] d, input logic rdy);
        bus_a.ib_nx_valid_i = v;
        bus_a.ib_nx_data_i  = d;
        bus_a.ob_nx_ready_i = rdy;
        bus_b.ib_nx_valid_i = v;
        bus_b.ib_nx_data_i  = d;
        bus_b.ob_nx_ready_i = rdy;
    endtask

    // Source model and scoreboard state.
    int total[4];
    int sent[4];
    int exp_seq[4];
    int n_out;
    int xfer_log[$];
    logic [3:0]  s_grant, s_ready;
    logic        s_ovalid;
    logic [31:0] s_odata;

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            total[k]   = 0;
            sent[k]    = 0;
            exp_seq[k] = 0;
        end
        n_out = 0;
        xfer_log.delete();
    endtask

    task automatic reset_all();
        rst_n  = 1'b0;
        ob_rdy = 1'b1;
        apply('0, '0, 1'b1);
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One cycle: sources offer message {id, seq} while they have any left;
    // outputs sampled mid-cycle; handshakes take effect at the edge.
    task automatic auto_cycle();
        logic [3:0]       v;
        logic [3:0][31:0] d;
        logic [3:0]       hs;
        int               r;
        for (int k = 0; k < 4; k++) begin
            v[k] = (sent[k] < total[k]);
            d[k] = {8'(k), 24'(sent[k])};
        end
        apply(v, d, ob_rdy);
        @(negedge clk);
        s_grant  = m_grant;
        s_ready  = m_ready;
        s_ovalid = m_ovalid;
        s_odata  = m_odata;
        hs       = v & s_ready;
        check("ready_onehot", 32'($countones(s_ready) <= 1), 32'd1);
        if (s_ovalid && ob_rdy) begin
            r = int'(s_odata[31:24]);
            if (r < 4) begin
                check("order", s_odata, {8'(r), 24'(exp_seq[r])});
                exp_seq[r]++;
            end else begin
                check("out_src", 32'(r), 32'd0);
            end
            n_out++;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (hs[k]) begin
                sent[k]++;
                xfer_log.push_back(k);
            end
        end
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] d2;
        logic        rdy;
        logic [3:0]  exp_grant;
        logic [3:0]  exp_ready;
        logic        exp_ovalid;
        logic [31:0] exp_odata;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [3:0]       g_exp;
        logic [3:0][31:0] d;
        int               cyc;
        int               exp_order[$];

        use_b = 1'b0;
        // Single requester 2, six messages, bursts of four (cycle-indexed).
        vecs[0] = '{4'b0100, 32'h0200_0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 32'h0000_0000};
        vecs[1] = '{4'b0100, 32'h0200_0000, 1'b1, 4'b0100, 4'b0100, 1'b0, 32'h0000_0000};
        vecs[2] = '{4'b0100, 32'h0200_0001, 1'b1, 4'b0100, 4'b0100, 1'b1, 32'h0200_0000};
        vecs[3] = '{4'b0100, 32'h0200_0002, 1'b1, 4'b0100, 4'b0100, 1'b1, 32'h0200_0001};
        vecs[4] = '{4'b0100, 32'h0200_0003, 1'b1, 4'b0100, 4'b0100, 1'b1, 32'h0200_0002};
        vecs[5] = '{4'b0100, 32'h0200_0004, 1'b1, 4'b0000, 4'b0000, 1'b1, 32'h0200_0003};
        vecs[6] = '{4'b0100, 32'h0200_0004, 1'b1, 4'b0100, 4'b0100, 1'b0, 32'h0200_0003};
        vecs[7] = '{4'b0100, 32'h0200_0005, 1'b1, 4'b0100, 4'b0100, 1'b1, 32'h0200_0004};
        vecs[8] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0100, 4'b0100, 1'b1, 32'h0200_0005};
        vecs[9] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 32'h0200_0005};

        // Reset values on both instances.
        reset_all();
        check("rst_grant_a",  32'(bus_a.grant_o),       32'd0);
        check("rst_ready_a",  32'(bus_a.ib_nx_ready_o), 32'd0);
        check("rst_ovalid_a", 32'(bus_a.ob_nx_valid_o), 32'd0);
        check("rst_odata_a",  bus_a.ob_nx_data_o,       32'd0);
        check("rst_grant_b",  32'(bus_b.grant_o),       32'd0);
        check("rst_ovalid_b", 32'(bus_b.ob_nx_valid_o), 32'd0);

        // Vector table.
        for (int i = 0; i < 10; i++) begin
            d    = '0;
            d[2] = vecs[i].d2;
            apply(vecs[i].valid, d, vecs[i].rdy);
            @(negedge clk);
            check($sformatf("vec%0d_grant", i),  32'(m_grant),  32'(vecs[i].exp_grant));
            check($sformatf("vec%0d_ready", i),  32'(m_ready),  32'(vecs[i].exp_ready));
            check($sformatf("vec%0d_ovalid", i), 32'(m_ovalid), 32'(vecs[i].exp_ovalid));
            check($sformatf("vec%0d_odata", i),  m_odata,       vecs[i].exp_odata);
            @(posedge clk);
            #1;
        end

        // MAX_BURST=1, all four valid: grants rotate with no bubble.
        reset_all();
        use_b = 1'b1;
        for (int k = 0; k < 4; k++) total[k] = 20;
        auto_cycle();
        check("rot_c0_grant", 32'(s_grant), 32'd0);
        for (int c = 1; c < 12; c++) begin
            auto_cycle();
            g_exp = 4'b0001 << ((c - 1) % 4);
            check($sformatf("rot_c%0d_grant", c), 32'(s_grant), 32'(g_exp));
            if (c >= 2) check($sformatf("rot_c%0d_ovalid", c), 32'(s_ovalid), 32'd1);
        end
        use_b = 1'b0;

        // Requesters 0 and 3, ten messages each, bursts of four.
        reset_all();
        total[0] = 10;
        total[3] = 10;
        cyc = 0;
        while (n_out < 20 && cyc < 80) begin
            auto_cycle();
            cyc++;
        end
        check("alt_out_count", 32'(n_out), 32'd20);
        exp_order.delete();
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < ((b < 4) ? 4 : 2); k++) exp_order.push_back((b % 2 == 0) ? 0 : 3);
        end
        check("alt_xfer_count", 32'(xfer_log.size()), 32'd20);
        for (int i = 0; i < 20; i++) begin
            if (i < xfer_log.size())
                check($sformatf("alt_xfer%0d_src", i), 32'(xfer_log[i]), 32'(exp_order[i]));
        end

        // Downstream stall of five cycles in the middle of a burst.
        reset_all();
        total[1] = 10;
        repeat (3) auto_cycle();
        ob_rdy = 1'b0;
        for (int c = 3; c < 8; c++) begin
            auto_cycle();
            check($sformatf("bp_c%0d_ready", c),  32'(s_ready),  32'd0);
            check($sformatf("bp_c%0d_ovalid", c), 32'(s_ovalid), 32'd1);
            check($sformatf("bp_c%0d_odata", c),  s_odata,       32'h0100_0001);
            check($sformatf("bp_c%0d_grant", c),  32'(s_grant),  32'b0010);
        end
        ob_rdy = 1'b1;
        auto_cycle();
        check("bp_resume_ready", 32'(s_ready), 32'b0010);
        auto_cycle();
        auto_cycle();
        check("bp_burst_end_grant", 32'(s_grant), 32'd0);
        cyc = 0;
        while (n_out < 10 && cyc < 60) begin
            auto_cycle();
            cyc++;
        end
        check("bp_out_count", 32'(n_out), 32'd10);

        // Granted source drains after two messages; requester 1 takes over.
        reset_all();
        total[0] = 2;
        total[1] = 3;
        repeat (3) auto_cycle();
        auto_cycle();
        check("drop_c3_grant", 32'(s_grant), 32'b0001);
        auto_cycle();
        check("drop_c4_grant", 32'(s_grant), 32'b0010);
        check("drop_c4_ready", 32'(s_ready), 32'b0010);
        cyc = 0;
        while (n_out < 5 && cyc < 40) begin
            auto_cycle();
            cyc++;
        end
        check("drop_out_count", 32'(n_out), 32'd5);
        check("drop_seq0", 32'(exp_seq[0]), 32'd2);
        check("drop_seq1", 32'(exp_seq[1]), 32'd3);

        // Asynchronous reset while LOCKED with a message in the output stage.
        reset_all();
        total[2] = 4;
        total[3] = 6;
        repeat (6) auto_cycle();
        check("ar_pre_grant",  32'(s_grant),  32'b1000);
        check("ar_pre_ovalid", 32'(s_ovalid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_grant",  32'(bus_a.grant_o),       32'd0);
        check("ar_ready",  32'(bus_a.ib_nx_ready_o), 32'd0);
        check("ar_ovalid", 32'(bus_a.ob_nx_valid_o), 32'd0);
        check("ar_odata",  bus_a.ob_nx_data_o,       32'd0);
        clear_model();
        apply('0, '0, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        total[0] = 2;
        total[3] = 2;
        auto_cycle();
        check("ar_c0_grant", 32'(s_grant), 32'd0);
        auto_cycle();
        check("ar_c1_grant", 32'(s_grant), 32'b0001);
        cyc = 0;
        while (n_out < 4 && cyc < 40) begin
            auto_cycle();
            cyc++;
        end
        check("ar_out_count", 32'(n_out), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
